// File: rtl/vec_pkg.sv
// Shared vector-datapath definitions used by EXEC and write-back.
package vec_pkg;

   localparam int ELEMENTS_PER_REGISTER = 4;
   localparam int ELEM_WIDTH            = 32;
   localparam int NUM_VREGS             = 8;
   localparam int VREG_W                = $clog2(NUM_VREGS);
   localparam int VR_WIDTH              = ELEMENTS_PER_REGISTER * ELEM_WIDTH;

   // Default write-back buffer depth and per-register in-flight counter width
   localparam int WB_FIFO_DEPTH = 4;
   localparam int WB_PEND_W     = 3;

   localparam logic [VR_WIDTH-1:0] ZERO_VECTOR = '0;

   typedef logic [VREG_W-1:0]                vreg_idx_t;
   typedef logic [ELEMENTS_PER_REGISTER-1:0] lane_mask_t;
   typedef logic [VR_WIDTH-1:0]              vreg_data_t;

   // One buffered lane result: destination, per-lane enables, packed lanes
   typedef struct packed {
      vreg_idx_t  vd;
      lane_mask_t mask;
      vreg_data_t data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/vec_sync_fifo.sv
// Synchronous in-order FIFO with registered occupancy count.
// Push while full and pop while empty are ignored.
module vec_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count/pointers alone decide which entries are valid.
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vec_wb_stage.sv
// Vector write-back stage: buffers EXEC results, drains them into RVF
// write port 3, and tracks in-flight writes per register for RAW stalls.
module vec_wb_stage
   import vec_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
   parameter int PEND_W     = WB_PEND_W
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [VREG_W-1:0]                 in_vd,
   input  logic [VR_WIDTH-1:0]               in_data,
   input  logic [ELEMENTS_PER_REGISTER-1:0]  in_lane_mask,
   input  logic                              issue_valid,
   input  logic [VREG_W-1:0]                 issue_vd,
   output logic                              we3,
   output logic [VREG_W-1:0]                 a3,
   output logic [VR_WIDTH-1:0]               wd3,
   output logic [ELEMENTS_PER_REGISTER-1:0]  wmask3,
   input  logic                              rvf_ready,
   output logic [NUM_VREGS-1:0]              pending_mask,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   wb_entry_t         push_entry;
   wb_entry_t         head;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;

   logic [PEND_W-1:0] cnt [NUM_VREGS];
   logic [NUM_VREGS-1:0] inc;
   logic [NUM_VREGS-1:0] dec;
   logic [NUM_VREGS-1:0] inc_err;
   logic [NUM_VREGS-1:0] dec_err;
   logic                 push_err;

   assign push_entry = '{vd: in_vd, mask: in_lane_mask, data: in_data};
   assign push       = in_valid & in_ready;
   assign pop        = we3 & rvf_ready;

   vec_sync_fifo #(
      .WIDTH (WB_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Readiness follows the registered count only, never a same-cycle pop
   assign in_ready = ~fifo_full;

   // Head entry drives the RVF port; everything is forced to zero when empty
   assign we3    = ~fifo_empty;
   assign a3     = fifo_empty ? '0          : head.vd;
   assign wd3    = fifo_empty ? ZERO_VECTOR : head.data;
   assign wmask3 = fifo_empty ? '0          : head.mask;

   // Per-register increment/decrement requests and protocol-error detection
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      inc      = '0;
      dec      = '0;
      inc_err  = '0;
      dec_err  = '0;
      for (int r = 0; r < NUM_VREGS; r++) begin
         inc[r]     = issue_valid && (issue_vd == VREG_W'(r));
         dec[r]     = pop && (a3 == VREG_W'(r));
         inc_err[r] = inc[r] && !dec[r] && (cnt[r] == CNT_MAX);
         dec_err[r] = dec[r] && !inc[r] && (cnt[r] == '0);
      end
      push_err = push && (cnt[in_vd] == '0) && !inc[in_vd];
   end

   // Scoreboard counters; an overflow/underflow holds the counter
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_VREGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_VREGS; r++) begin
            if (inc[r] && !dec[r] && !inc_err[r])
               cnt[r] <= cnt[r] + PEND_W'(1);
            else if (dec[r] && !inc[r] && !dec_err[r])
               cnt[r] <= cnt[r] - PEND_W'(1);
         end
      end
   end

   // Pending bits derive from the registered counters
   always_comb begin
      pending_mask = '0;
      for (int r = 0; r < NUM_VREGS; r++) pending_mask[r] = (cnt[r] != '0);
   end

   a_no_overflow  : assert property (@(posedge clk) disable iff (reset) inc_err == '0);
   a_no_underflow : assert property (@(posedge clk) disable iff (reset) dec_err == '0);
   a_push_issued  : assert property (@(posedge clk) disable iff (reset) !push_err);

endmodule

// File: tb/tb_vec_wb_stage.sv
// Directed bench for vec_wb_stage: one task per scenario, inline checks.
module tb_vec_wb_stage;
   import vec_pkg::*;

   logic                             clk = 1'b0;
   logic                             reset;
   logic                             in_valid;
   logic                             in_ready;
   logic [VREG_W-1:0]                in_vd;
   logic [VR_WIDTH-1:0]              in_data;
   logic [ELEMENTS_PER_REGISTER-1:0] in_lane_mask;
   logic                             issue_valid;
   logic [VREG_W-1:0]                issue_vd;
   logic                             we3;
   logic [VREG_W-1:0]                a3;
   logic [VR_WIDTH-1:0]              wd3;
   logic [ELEMENTS_PER_REGISTER-1:0] wmask3;
   logic                             rvf_ready;
   logic [NUM_VREGS-1:0]             pending_mask;
   logic [2:0]                       fifo_count;

   int checks = 0;
   int errors = 0;

   vec_wb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_vd        (in_vd),
      .in_data      (in_data),
      .in_lane_mask (in_lane_mask),
      .issue_valid  (issue_valid),
      .issue_vd     (issue_vd),
      .we3          (we3),
      .a3           (a3),
      .wd3          (wd3),
      .wmask3       (wmask3),
      .rvf_ready    (rvf_ready),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Distinct packed data per tag: lanes tag*16+1 .. tag*16+4
   function automatic logic [VR_WIDTH-1:0] mk(input int tag);
      return {32'(tag*16+4), 32'(tag*16+3), 32'(tag*16+2), 32'(tag*16+1)};
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [VREG_W-1:0] vd);
      issue_valid = 1'b1;
      issue_vd    = vd;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic push(input logic [VREG_W-1:0] vd, input logic [VR_WIDTH-1:0] d,
                       input logic [ELEMENTS_PER_REGISTER-1:0] m);
      in_valid     = 1'b1;
      in_vd        = vd;
      in_data      = d;
      in_lane_mask = m;
      tick();
      in_valid     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({we3, a3, wd3, wmask3} !== '0) begin
         errors++;
         $display("FAIL rst_port got we3=%0b a3=%0d wd3=%h wmask3=%h exp all 0", we3, a3, wd3, wmask3);
      end
      checks++;
      if (pending_mask !== 8'h00) begin
         errors++; $display("FAIL rst_pending got=%h exp=00", pending_mask);
      end
      checks++;
      if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_count got count=%0d ready=%0b exp 0/1", fifo_count, in_ready);
      end
   endtask

   task automatic test_single();
      rvf_ready = 1'b1;
      issue(3'd3);
      checks++;
      if (pending_mask !== 8'h08 || we3 !== 1'b0) begin
         errors++; $display("FAIL t1_issue got pend=%h we3=%0b exp 08/0", pending_mask, we3);
      end
      push(3'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF);
      checks++;
      if (we3 !== 1'b1 || a3 !== 3'd3) begin
         errors++; $display("FAIL t1_write got we3=%0b a3=%0d exp 1/3", we3, a3);
      end
      checks++;
      if (wd3 !== {32'd4, 32'd3, 32'd2, 32'd1} || wmask3 !== 4'hF || pending_mask !== 8'h08) begin
         errors++; $display("FAIL t1_data got wd3=%h wmask3=%h pend=%h", wd3, wmask3, pending_mask);
      end
      tick();
      checks++;
      if (we3 !== 1'b0 || fifo_count !== 3'd0 || pending_mask !== 8'h00 || wd3 !== '0 || a3 !== 3'd0) begin
         errors++; $display("FAIL t1_drain got we3=%0b cnt=%0d pend=%h a3=%0d", we3, fifo_count, pending_mask, a3);
      end
   endtask

   task automatic test_fill_and_drain();
      logic [NUM_VREGS-1:0] exp_pend;
      rvf_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(3'(i));
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL t2_ready%0d got=%0b exp=1", i, in_ready);
         end
         push(3'(i), mk(i), (i == 3) ? 4'h0 : 4'(1 << i));
      end
      checks++;
      if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
         errors++; $display("FAIL t2_full got ready=%0b cnt=%0d exp 0/4", in_ready, fifo_count);
      end
      push(3'd7, mk(9), 4'hF);
      checks++;
      if (fifo_count !== 3'd4 || a3 !== 3'd0 || wd3 !== mk(0)) begin
         errors++; $display("FAIL t2_hold got cnt=%0d a3=%0d wd3=%h", fifo_count, a3, wd3);
      end
      rvf_ready = 1'b1;
      exp_pend  = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (we3 !== 1'b1 || a3 !== 3'(i) || wd3 !== mk(i) || pending_mask !== exp_pend) begin
            errors++; $display("FAIL t2_order%0d got we3=%0b a3=%0d pend=%h exp a3=%0d pend=%h",
                               i, we3, a3, pending_mask, i, exp_pend);
         end
         checks++;
         if (wmask3 !== ((i == 3) ? 4'h0 : 4'(1 << i))) begin
            errors++; $display("FAIL t2_mask%0d got=%h", i, wmask3);
         end
         exp_pend[i] = 1'b0;
         tick();
      end
      checks++;
      if (we3 !== 1'b0 || fifo_count !== 3'd0 || pending_mask !== 8'h00) begin
         errors++; $display("FAIL t2_empty got we3=%0b cnt=%0d pend=%h", we3, fifo_count, pending_mask);
      end
   endtask

   task automatic test_full_with_pop();
      rvf_ready = 1'b0;
      for (int i = 0; i < 5; i++) issue(3'd4);
      for (int i = 0; i < 4; i++) push(3'd4, mk(20 + i), 4'hA);
      rvf_ready = 1'b1;
      push(3'd4, mk(30), 4'h5);
      checks++;
      if (fifo_count !== 3'd3 || in_ready !== 1'b1 || pending_mask !== 8'h10) begin
         errors++; $display("FAIL t3_refuse got cnt=%0d ready=%0b pend=%h exp 3/1/10", fifo_count, in_ready, pending_mask);
      end
      rvf_ready = 1'b0;
      push(3'd4, mk(30), 4'h5);
      checks++;
      if (fifo_count !== 3'd4) begin
         errors++; $display("FAIL t3_accept got cnt=%0d exp=4", fifo_count);
      end
      rvf_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wd3 !== ((i == 3) ? mk(30) : mk(21 + i))) begin
            errors++; $display("FAIL t3_order%0d got wd3=%h", i, wd3);
         end
         tick();
      end
      checks++;
      if (fifo_count !== 3'd0 || pending_mask !== 8'h00) begin
         errors++; $display("FAIL t3_empty got cnt=%0d pend=%h", fifo_count, pending_mask);
      end
   endtask

   task automatic test_pending_two();
      rvf_ready = 1'b0;
      issue(3'd5);
      issue(3'd5);
      push(3'd5, mk(40), 4'hF);
      push(3'd5, mk(41), 4'hF);
      rvf_ready = 1'b1;
      tick();
      checks++;
      if (pending_mask !== 8'h20 || fifo_count !== 3'd1) begin
         errors++; $display("FAIL t4_first got pend=%h cnt=%0d exp 20/1", pending_mask, fifo_count);
      end
      tick();
      checks++;
      if (pending_mask !== 8'h00 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL t4_second got pend=%h cnt=%0d exp 00/0", pending_mask, fifo_count);
      end
   endtask

   task automatic test_same_cycle_inc_dec();
      rvf_ready = 1'b0;
      issue(3'd2);
      push(3'd2, mk(50), 4'h3);
      rvf_ready = 1'b1;
      issue(3'd2);
      checks++;
      if (pending_mask !== 8'h04 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL t5_hold got pend=%h cnt=%0d exp 04/0", pending_mask, fifo_count);
      end
      push(3'd2, mk(51), 4'h3);
      tick();
      checks++;
      if (pending_mask !== 8'h00) begin
         errors++; $display("FAIL t5_clear got pend=%h exp=00", pending_mask);
      end
   endtask

   task automatic test_back_to_back();
      rvf_ready = 1'b0;
      for (int i = 0; i < 6; i++) issue(3'd7);
      rvf_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push(3'd7, mk(60 + i), 4'hC);
         checks++;
         if (fifo_count !== 3'd1 || wd3 !== mk(60 + i) || a3 !== 3'd7) begin
            errors++; $display("FAIL t7_stream%0d got cnt=%0d wd3=%h a3=%0d", i, fifo_count, wd3, a3);
         end
      end
      tick();
      checks++;
      if (fifo_count !== 3'd0 || pending_mask !== 8'h00) begin
         errors++; $display("FAIL t7_end got cnt=%0d pend=%h", fifo_count, pending_mask);
      end
   endtask

   task automatic test_reset_mid();
      rvf_ready = 1'b0;
      issue(3'd1);
      issue(3'd6);
      issue(3'd7);
      push(3'd1, mk(70), 4'hF);
      push(3'd6, mk(71), 4'hF);
      push(3'd7, mk(72), 4'hF);
      checks++;
      if (fifo_count !== 3'd3 || pending_mask !== 8'hC2) begin
         errors++; $display("FAIL t6_pre got cnt=%0d pend=%h exp 3/C2", fifo_count, pending_mask);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (we3 !== 1'b0 || fifo_count !== 3'd0 || pending_mask !== 8'h00 || in_ready !== 1'b1) begin
         errors++; $display("FAIL t6_reset got we3=%0b cnt=%0d pend=%h ready=%0b", we3, fifo_count, pending_mask, in_ready);
      end
      reset     = 1'b0;
      rvf_ready = 1'b1;
      tick();
      checks++;
      if (we3 !== 1'b0 || a3 !== 3'd0 || wd3 !== '0) begin
         errors++; $display("FAIL t6_after got we3=%0b a3=%0d wd3=%h", we3, a3, wd3);
      end
   endtask

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_vd        = '0;
      in_data      = '0;
      in_lane_mask = '0;
      issue_valid  = 1'b0;
      issue_vd     = '0;
      rvf_ready    = 1'b0;
      test_reset();
      test_single();
      test_fill_and_drain();
      test_full_with_pop();
      test_pending_two();
      test_same_cycle_inc_dec();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
